// File: rtl/alu_ctrl8.sv
// 8-bit ALU controller: one-cycle logic/add/sub operations plus an 8-step shift-add multiplier.
// Results are published only on the DONE transition and hold until the next completion.
module alu_ctrl8 #(
    parameter logic MUL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cout,
    output logic        zero,
    output logic        err
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EXEC     = 2'd1;
    localparam logic [1:0] MUL_LOOP = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    // Returns {carry, value}; SUB carry is the no-borrow flag of a + ~b + 1.
    function automatic logic [8:0] alu_eval(input logic [2:0] f_op, input logic [7:0] f_a,
                                            input logic [7:0] f_b);
        logic [8:0] r;
        r = 9'h000;
        case (f_op)
            OP_AND:  r = {1'b0, f_a & f_b};
            OP_OR:   r = {1'b0, f_a | f_b};
            OP_XOR:  r = {1'b0, f_a ^ f_b};
            OP_NOT:  r = {1'b0, ~f_a};
            OP_ADD:  r = {1'b0, f_a} + {1'b0, f_b};
            OP_SUB:  r = {1'b0, f_a} + {1'b0, ~f_b} + 9'd1;
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    function automatic logic op_legal(input logic [2:0] f_op);
        logic ok;
        if (f_op == OP_ILL) begin
            ok = 1'b0;
        end else if (f_op == OP_MUL) begin
            ok = MUL_EN;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d, b_q, b_d, mplr_q, mplr_d;
    logic [15:0] prod_q, prod_d, result_q, result_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        cout_q, cout_d, zero_q, zero_d, err_q, err_d, busy_q, busy_d, done_q, done_d;
    logic [8:0]  mul_sum_s, alu_s;
    logic [15:0] mul_prod_s;

    // Datapath helpers: one shift-add step and the single-cycle ALU value.
    always_comb begin
        mul_sum_s  = {1'b0, prod_q[15:8]} + (mplr_q[0] ? {1'b0, a_q} : 9'h000);
        mul_prod_s = {mul_sum_s, prod_q[7:1]};
        alu_s      = alu_eval(op_q, a_q, b_q);
    end

    // Next-state and next-output logic for the controller FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mplr_d   = mplr_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (!op_legal(op_q)) begin
                    result_d = 16'h0000;
                    cout_d   = 1'b0;
                    zero_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else if (op_q == OP_MUL) begin
                    prod_d  = 16'h0000;
                    cnt_d   = 3'd0;
                    mplr_d  = b_q;
                    state_d = MUL_LOOP;
                end else begin
                    result_d = {8'h00, alu_s[7:0]};
                    cout_d   = alu_s[8];
                    zero_d   = (alu_s[7:0] == 8'h00);
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            MUL_LOOP: begin
                prod_d = mul_prod_s;
                mplr_d = {1'b0, mplr_q[7:1]};
                cnt_d  = cnt_q + 3'd1;
                // The eighth step publishes the freshly formed product directly.
                if (cnt_q == 3'd7) begin
                    result_d = mul_prod_s;
                    cout_d   = 1'b0;
                    zero_d   = (mul_prod_s == 16'h0000);
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else begin
                    state_d = MUL_LOOP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            mplr_q   <= 8'h00;
            prod_q   <= 16'h0000;
            cnt_q    <= 3'd0;
            result_q <= 16'h0000;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mplr_q   <= mplr_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_ctrl8.sv
// Scoreboard bench for alu_ctrl8: expectations queued at acceptance, checked on each done pulse.
module tb_alu_ctrl8;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic        busy, done, cout, zero, err;
    logic [15:0] result;

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        err;
        int          done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_ctrl8 #(.MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference behaviour written from the operation table.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        logic [8:0] s;
        e.res = 16'h0000; e.cout = 1'b0; e.err = 1'b0; e.done_cyc = 0;
        case (o)
            3'b000: e.res = {8'h00, x & y};
            3'b001: e.res = {8'h00, x | y};
            3'b010: e.res = {8'h00, x ^ y};
            3'b011: e.res = {8'h00, ~x};
            3'b100: begin s = {1'b0, x} + {1'b0, y}; e.res = {8'h00, s[7:0]}; e.cout = s[8]; end
            3'b101: begin s = {1'b0, x} - {1'b0, y}; e.res = {8'h00, s[7:0]}; e.cout = (x >= y); end
            3'b110: e.res = 16'(x) * 16'(y);
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic push(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        e = model(o, x, y);
        e.done_cyc = cyc + ((o == 3'b110) ? 9 : 1);
        exp_q.push_back(e);
    endtask

    // Completion monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("result", 32'(result), 32'(e.res));
                check_eq("cout", 32'(cout), 32'(e.cout));
                check_eq("zero", 32'(zero), 32'(e.res == 16'h0000));
                check_eq("err", 32'(err), 32'(e.err));
                check_eq("done_cycle", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    task automatic wait_done(output int n_busy, output bit seen);
        n_busy = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input bit hold, input logic [2:0] o2, input logic [7:0] x2,
                          input logic [7:0] y2);
        int n_busy;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        push(o, x, y);
        if (hold) begin
            op = o2; a = x2; b = y2;
        end else begin
            start = 1'b0;
            op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
        end
        wait_done(n_busy, seen);
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("busy_len", 32'(n_busy), (o == 3'b110) ? 32'd10 : 32'd2);
        if (hold) begin
            @(posedge clk); #1;
            check_eq("idle_gap_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
            push(o2, x2, y2);
            start = 1'b0;
            wait_done(n_busy, seen);
            check_eq("done_seen2", 32'(seen), 32'd1);
        end
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        rst = 1'b1; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        run_op(3'b100, 8'hF0, 8'h20, 1'b0, 3'b000, 8'h00, 8'h00);
        run_op(3'b101, 8'h05, 8'h07, 1'b0, 3'b000, 8'h00, 8'h00);
        run_op(3'b101, 8'h07, 8'h07, 1'b0, 3'b000, 8'h00, 8'h00);
        run_op(3'b110, 8'hFF, 8'hFF, 1'b0, 3'b000, 8'h00, 8'h00);
        run_op(3'b110, 8'h00, 8'h37, 1'b0, 3'b000, 8'h00, 8'h00);
        run_op(3'b110, 8'h12, 8'h34, 1'b1, 3'b100, 8'h55, 8'h66);
        run_op(3'b111, 8'hAA, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00);
        run_op(3'b000, 8'hAA, 8'h0F, 1'b0, 3'b000, 8'h00, 8'h00);
        run_op(3'b011, 8'h3C, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00);

        // Reset at T+5 of a multiply aborts it silently.
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = 8'h9D; b = 8'hC3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("busy_mid_mul", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_result", 32'(result), 32'd0);
        check_eq("abort_err", 32'(err), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_eq("no_done_after_abort", 32'(saw_done), 32'd0);

        // Reset wins over start in the same cycle.
        rst = 1'b1; start = 1'b1; op = 3'b100; a = 8'h01; b = 8'h01;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_eq("rst_over_start", 32'(busy), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0,
                   3'b000, 8'h00, 8'h00);
        end
        run_op(3'b001, 8'hA0, 8'h05, 1'b1, 3'b010, 8'hFF, 8'h0F);

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_ctrl8.md
ALU_CTRL8 -- requirements
Module: alu_ctrl8

Interface
REQ-001 Parameter: MUL_EN, default 1; 1 enables op 3'b110 (MUL), 0 makes op 3'b110 illegal.
REQ-002 Clock and reset are fixed as follows.
- One clock: clk.
- Reset: rst, synchronous, active-high.
REQ-003 Ports (name direction width meaning):
- clk input 1: sole clock, rising edge.
- rst input 1: synchronous active-high reset.
- start input 1: operation request, sampled only in IDLE.
- op input 3: 000 AND, 001 OR, 010 XOR, 011 NOT a, 100 ADD, 101 SUB, 110 MUL, 111 illegal.
- a input 8: operand A.
- b input 8: operand B.
- busy output 1: high whenever state is not IDLE.
- done output 1: one-cycle completion pulse.
- result output 16: operation result.
- cout output 1: carry / no-borrow flag.
- zero output 1: result equals 0.
- err output 1: last accepted op was illegal.

Function
REQ-004 States SHALL be IDLE, EXEC, MUL_LOOP and DONE; all outputs SHALL be registered.
REQ-005 Acceptance SHALL follow these rules.
- In IDLE with start=1 at cycle T: latch op, a and b; go to EXEC at T+1.
- start is ignored in EXEC, MUL_LOOP and DONE.
REQ-006 EXEC, non-MUL op: compute from the latched operands, register the outputs, go to DONE at T+2.
REQ-007 Logic ops (AND, OR, XOR, NOT): result = {8'h00, 8-bit value}, cout = 0.
REQ-008 ADD: result = {8'h00, (a+b)[7:0]}, cout = carry out of bit 7.
REQ-009 SUB: computed as a + ~b + 1, result = {8'h00, low byte}; cout = 1 when no borrow (a >= b unsigned), 0 otherwise.
REQ-010 Illegal op (111, or 110 with MUL_EN=0): result = 16'h0000, cout = 0, err = 1, completes on the same T+2 timing; err = 0 for every legal op.
REQ-011 EXEC, MUL: clear the 16-bit product and the 3-bit iteration counter, load the multiplier shift register with b, go to MUL_LOOP at T+2.
REQ-012 Each MUL_LOOP cycle SHALL perform one shift-add step.
- If multiplier[0]=1, add a into product[15:8] with 9-bit carry capture; then shift {carry, product} right by 1 and shift the multiplier right by 1.
- Otherwise only shift.
- Exactly 8 iterations (T+2..T+9), then go to DONE at T+10.
REQ-013 MUL result SHALL be the unsigned 16-bit product a*b, with cout = 0.
REQ-014 The internal result accumulator SHALL NOT drive the result output before DONE; result, cout, zero and err SHALL hold their previous completion values until the next DONE.
REQ-015 zero SHALL equal (result == 16'h0000), updated in the same cycle as result.
REQ-016 DONE SHALL assert done=1 and busy=1 for exactly one cycle, then return unconditionally to IDLE; start during DONE is ignored.
REQ-017 A new start SHALL be accepted no earlier than the first IDLE cycle after DONE, so back-to-back ops are separated by at least one IDLE cycle.
REQ-018 Operand or op changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-019 rst=1 at a rising edge SHALL force the following on the next cycle, regardless of state.
- State: IDLE.
- Outputs: busy=0, done=0, result=16'h0000, cout=0, zero=0, err=0.
- Internal state: counter, product and latched operands cleared.
REQ-020 Reset mid-operation (EXEC or MUL_LOOP) SHALL abort with no done pulse and no update of result, cout, zero or err.
REQ-021 Reset SHALL take priority over start in the same cycle.

Verification
REQ-022 ADD a=8'hF0, b=8'h20, start at T -> done=1 at T+2 only, result=16'h0010, cout=1, zero=0, err=0.
REQ-023 SUB a=8'h05, b=8'h07 -> result=16'h00FE, cout=0; SUB a=8'h07, b=8'h07 -> result=16'h0000, cout=1, zero=1.
REQ-024 MUL a=8'hFF, b=8'hFF, start at T -> busy=1 T+1..T+10, done=1 at T+10, result=16'hFE01, cout=0; MUL a=8'h00, b=8'h37 -> result=16'h0000, zero=1.
REQ-025 start=1 with new operands held during MUL_LOOP and DONE -> ignored, first result unaffected; a new op is accepted only in the following IDLE cycle.
REQ-026 rst=1 at T+5 of a MUL -> next cycle busy=0, done=0, result=16'h0000; no done pulse at T+10.
REQ-027 op=3'b111 with a=8'hAA -> done at T+2, result=16'h0000, err=1, zero=1; a subsequent AND a=8'hAA, b=8'h0F -> result=16'h000A, err=0.
